// File: rtl/gpio_bank.sv
// gpio_bank: NUM_PORTS x PORT_SIZE GPIO with DDR/PVL/PIN/TGL registers,
// a pin synchroniser and registered bus reads.
// Optional feature macro GPIO_BANK_IRQ_EN: RISE/FALL/IFR edge flags, the
// edge-priming counter and the irq line. Without it irq is tied low.
module gpio_bank #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      ADDRW       = 11,
  parameter int unsigned      NUM_PORTS   = 2,
  parameter int unsigned      PORT_SIZE   = 8,
  parameter logic [ADDRW-1:0] BASE_ADDR   = 11'h408,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rstB,
  input  logic [ADDRW-1:0]               addr,
  input  logic [XLEN-1:0]                wrData,
  input  logic                           wrEn,
  input  logic                           rdEn,
  output logic [XLEN-1:0]                dataOut,
  output logic                           outEn,
  output logic [NUM_PORTS*PORT_SIZE-1:0] ddr,
  output logic [NUM_PORTS*PORT_SIZE-1:0] pvl,
  input  logic [NUM_PORTS*PORT_SIZE-1:0] pin,
  output logic                           irq
);

  localparam int unsigned WIDTH  = NUM_PORTS * PORT_SIZE;
  localparam int unsigned PSELW  = ADDRW - 3;
  localparam int unsigned ADDRW1 = ADDRW + 1;

  localparam logic [2:0] OFF_DDR  = 3'd0;
  localparam logic [2:0] OFF_PVL  = 3'd1;
  localparam logic [2:0] OFF_PIN  = 3'd2;
  localparam logic [2:0] OFF_TGL  = 3'd3;
  localparam logic [2:0] OFF_RISE = 3'd4;
  localparam logic [2:0] OFF_FALL = 3'd5;
  localparam logic [2:0] OFF_IFR  = 3'd6;

  localparam logic [ADDRW:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDRW:0] ADDR_HI = ADDRW1'(32'(BASE_ADDR) + 8 * NUM_PORTS);

  logic [ADDRW:0]       addrExt;
  logic                 inRange;
  logic [ADDRW-1:0]     relAddr;
  logic [PSELW-1:0]     portSel;
  logic [2:0]           regOff;
  logic [NUM_PORTS-1:0] portHit;
  logic [PORT_SIZE-1:0] wrPort;
  logic [PORT_SIZE-1:0] rdVal;

  logic [PORT_SIZE-1:0] ddrQ [NUM_PORTS];
  logic [PORT_SIZE-1:0] pvlQ [NUM_PORTS];
  logic [WIDTH-1:0]     syncQ [SYNC_STAGES];
  logic [WIDTH-1:0]     pinSync;

  // Address decode: window check plus port index and register offset
  assign addrExt = {1'b0, addr};
  assign inRange = (addrExt >= ADDR_LO) && (addrExt < ADDR_HI);
  assign relAddr = addr - BASE_ADDR;
  assign portSel = relAddr[ADDRW-1:3];
  assign regOff  = relAddr[2:0];
  assign wrPort  = wrData[PORT_SIZE-1:0];

  // One-hot port select, only inside the register window
  always_comb begin
    portHit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      portHit[p] = inRange && (portSel == PSELW'(p));
    end
  end

  generate
    if (PORT_SIZE < XLEN) begin : gUnusedWr
      logic unusedWrBits;
      assign unusedWrBits = ^wrData[XLEN-1:PORT_SIZE];
    end
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : gPortOut
      assign ddr[gp*PORT_SIZE +: PORT_SIZE] = ddrQ[gp];
      assign pvl[gp*PORT_SIZE +: PORT_SIZE] = pvlQ[gp];
    end
  endgenerate

  // Direction and output-value registers, including write-1-to-toggle
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        ddrQ[p] <= '0;
        pvlQ[p] <= '0;
      end
    end else if (wrEn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (portHit[p]) begin
          case (regOff)
            OFF_DDR: ddrQ[p] <= wrPort;
            OFF_PVL: pvlQ[p] <= wrPort;
            OFF_TGL: pvlQ[p] <= pvlQ[p] ^ wrPort;
            default: ;
          endcase
        end
      end
    end
  end

  // Pad input synchroniser chain
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncQ[s] <= '0;
      end
    end else begin
      syncQ[0] <= pin;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncQ[s] <= syncQ[s-1];
      end
    end
  end

  assign pinSync = syncQ[SYNC_STAGES-1];

`ifdef GPIO_BANK_IRQ_EN
  localparam int unsigned PRIME_CNT = SYNC_STAGES + 1;
  localparam int unsigned PRIMEW    = $clog2(PRIME_CNT + 1);

  logic [PRIMEW-1:0]    primeCnt;
  logic                 primed;
  logic [WIDTH-1:0]     prevQ;
  logic [WIDTH-1:0]     riseEdge;
  logic [WIDTH-1:0]     fallEdge;
  logic [PORT_SIZE-1:0] riseQ [NUM_PORTS];
  logic [PORT_SIZE-1:0] fallQ [NUM_PORTS];
  logic [PORT_SIZE-1:0] ifrQ [NUM_PORTS];
  logic [PORT_SIZE-1:0] ifrNext [NUM_PORTS];
  logic                 anyFlag;

  // Priming counter: holds off edge detection until the chain has filled
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      primeCnt <= '0;
    end else if (!primed) begin
      primeCnt <= primeCnt + PRIMEW'(1);
    end
  end

  assign primed   = (primeCnt == PRIMEW'(PRIME_CNT));
  assign riseEdge = primed ? (pinSync & ~prevQ) : '0;
  assign fallEdge = primed ? (~pinSync & prevQ) : '0;

  // Previous synchronised value for edge detection
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      prevQ <= '0;
    end else begin
      prevQ <= pinSync;
    end
  end

  // Next flag state: W1C applied first so a same-cycle set wins
  always_comb begin
    anyFlag = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      ifrNext[p] = (ifrQ[p] & ~((wrEn && portHit[p] && (regOff == OFF_IFR)) ? wrPort : '0))
                 | (riseEdge[p*PORT_SIZE +: PORT_SIZE] & riseQ[p])
                 | (fallEdge[p*PORT_SIZE +: PORT_SIZE] & fallQ[p]);
      anyFlag    = anyFlag | (|ifrNext[p]);
    end
  end

  // Edge masks, sticky flags and the interrupt flop
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        riseQ[p] <= '0;
        fallQ[p] <= '0;
        ifrQ[p]  <= '0;
      end
      irq <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        ifrQ[p] <= ifrNext[p];
        if (wrEn && portHit[p] && (regOff == OFF_RISE)) begin
          riseQ[p] <= wrPort;
        end
        if (wrEn && portHit[p] && (regOff == OFF_FALL)) begin
          fallQ[p] <= wrPort;
        end
      end
      irq <= anyFlag;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; TGL, reserved and absent registers return 0
  always_comb begin
    rdVal = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (portHit[p]) begin
        case (regOff)
          OFF_DDR:  rdVal = ddrQ[p];
          OFF_PVL:  rdVal = pvlQ[p];
          OFF_PIN:  rdVal = pinSync[p*PORT_SIZE +: PORT_SIZE];
`ifdef GPIO_BANK_IRQ_EN
          OFF_RISE: rdVal = riseQ[p];
          OFF_FALL: rdVal = fallQ[p];
          OFF_IFR:  rdVal = ifrQ[p];
`endif
          default:  rdVal = '0;
        endcase
      end
    end
  end

  // Registered read response, zero when not valid
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      outEn   <= 1'b0;
      dataOut <= '0;
    end else begin
      outEn   <= rdEn && inRange;
      dataOut <= (rdEn && inRange) ? XLEN'(rdVal) : '0;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed + random bench for gpio_bank against a delay-line
// reference model of the register map, synchroniser and edge flags.
module tb_gpio_bank;

`ifdef GPIO_BANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int NP   = 2;
  localparam int PS   = 8;
  localparam int SS   = 2;
  localparam int BASE = 'h408;

  logic        clk;
  logic        rstB;
  logic [10:0] addr;
  logic [31:0] wrData;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] dataOut;
  logic        outEn;
  logic [15:0] ddr;
  logic [15:0] pvl;
  logic [15:0] pin;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  mDdr  [NP];
  logic [7:0]  mPvl  [NP];
  logic [7:0]  mRise [NP];
  logic [7:0]  mFall [NP];
  logic [7:0]  mIfr  [NP];
  logic [15:0] mHist [SS+1];
  int          mCnt;

  gpio_bank dut (
    .clk(clk), .rstB(rstB), .addr(addr), .wrData(wrData), .wrEn(wrEn),
    .rdEn(rdEn), .dataOut(dataOut), .outEn(outEn), .ddr(ddr), .pvl(pvl),
    .pin(pin), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] regAddr(input int p, input int off);
    return 11'(BASE + 8 * p + off);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < NP; p++) begin
      mDdr[p] = '0; mPvl[p] = '0; mRise[p] = '0; mFall[p] = '0; mIfr[p] = '0;
    end
    for (int i = 0; i <= SS; i++) mHist[i] = '0;
    mCnt = 0;
  endtask

  // One clock: predict from current inputs, advance, compare all outputs
  task automatic tick();
    int          a, pIdx, off;
    logic        inR, live, expOutEn, anyF;
    logic [7:0]  rv, wd, clr, setB;
    logic [15:0] syn, prv, rise, fall;
    logic [31:0] expData;
    a    = int'(addr);
    inR  = (a >= BASE) && (a < BASE + 8 * NP);
    pIdx = inR ? (a - BASE) / 8 : 0;
    off  = inR ? (a - BASE) % 8 : 7;
    wd   = wrData[7:0];
    syn  = mHist[SS-1];
    prv  = mHist[SS];
    rv   = '0;
    case (off)
      0: rv = mDdr[pIdx];
      1: rv = mPvl[pIdx];
      2: rv = syn[pIdx*PS +: PS];
      4: rv = IRQ_EN ? mRise[pIdx] : 8'h00;
      5: rv = IRQ_EN ? mFall[pIdx] : 8'h00;
      6: rv = IRQ_EN ? mIfr[pIdx]  : 8'h00;
      default: rv = '0;
    endcase
    expOutEn = rdEn && inR;
    expData  = expOutEn ? {24'h0, rv} : 32'h0;
    rise = syn & ~prv;
    fall = ~syn & prv;
    live = IRQ_EN && (mCnt >= SS + 1);
    anyF = 1'b0;
    for (int p = 0; p < NP; p++) begin
      clr  = (wrEn && inR && pIdx == p && off == 6) ? wd : 8'h00;
      setB = live ? ((rise[p*PS +: PS] & mRise[p]) | (fall[p*PS +: PS] & mFall[p])) : 8'h00;
      mIfr[p] = IRQ_EN ? ((mIfr[p] & ~clr) | setB) : 8'h00;
      anyF = anyF | (|mIfr[p]);
    end
    if (wrEn && inR) begin
      case (off)
        0: mDdr[pIdx] = wd;
        1: mPvl[pIdx] = wd;
        3: mPvl[pIdx] = mPvl[pIdx] ^ wd;
        4: if (IRQ_EN) mRise[pIdx] = wd;
        5: if (IRQ_EN) mFall[pIdx] = wd;
        default: ;
      endcase
    end
    for (int i = SS; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = pin;
    mCnt++;
    @(posedge clk);
    #1;
    check("outEn", 32'(outEn), 32'(expOutEn));
    check("dataOut", dataOut, expData);
    check("ddr", 32'(ddr), {16'h0, mDdr[1], mDdr[0]});
    check("pvl", 32'(pvl), {16'h0, mPvl[1], mPvl[0]});
    check("irq", 32'(irq), 32'(anyF));
  endtask

  task automatic doReset();
    wrEn = 1'b0;
    rdEn = 1'b0;
    @(negedge clk);
    rstB = 1'b0;
    modelReset();
    #1;
    check("rst_ddr", 32'(ddr), 32'h0);
    check("rst_pvl", 32'(pvl), 32'h0);
    check("rst_outEn", 32'(outEn), 32'h0);
    check("rst_dataOut", dataOut, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstB = 1'b1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    addr = a; wrData = d; wrEn = 1'b1;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a, input logic [31:0] exp, input string tag);
    addr = a; rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    check(tag, dataOut, exp);
    check({tag, "_valid"}, 32'(outEn), 32'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clk = 1'b0; rstB = 1'b0; addr = '0; wrData = '0;
    wrEn = 1'b0; rdEn = 1'b0; pin = '0;
    modelReset();
    doReset();

    // All registers read zero after reset
    for (int p = 0; p < NP; p++)
      for (int o = 0; o < 8; o++)
        rd(regAddr(p, o), 32'h0, "reset_read");

    // Out-of-range read never validates
    addr = 11'h400; rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    check("oob_outEn", 32'(outEn), 32'h0);
    tick();
    check("oob_outEn_after", 32'(outEn), 32'h0);

    // DDR/PVL write and toggle on port 1
    wr(regAddr(1, 0), 32'h0000_00F0);
    wr(regAddr(1, 1), 32'h0000_00A5);
    wr(regAddr(1, 3), 32'h0000_000F);
    check("ddr1", 32'(ddr[15:8]), 32'hF0);
    check("pvl1", 32'(pvl[15:8]), 32'hAA);
    rd(regAddr(1, 3), 32'h0, "tgl_read");
    rd(regAddr(1, 1), 32'hAA, "pvl1_read");

    // Rising edge on pin[3]: sync latency, flag, irq and W1C
    wr(regAddr(0, 4), 32'h08);
    pin = 16'h0008;
    idle(2);
    rd(regAddr(0, 2), 32'h08, "pin0_sync");
    check("irq_rise", 32'(irq), 32'(IRQ_EN));
    rd(regAddr(0, 6), IRQ_EN ? 32'h08 : 32'h0, "ifr0_rise");
    wr(regAddr(0, 6), 32'h08);
    check("irq_w1c", 32'(irq), 32'h0);

    // W1C colliding with a new rising edge: set wins
    wr(regAddr(0, 4), 32'h09);
    pin = 16'h0009;
    idle(3);
    pin = 16'h0008;
    idle(3);
    pin = 16'h0009;
    idle(2);
    wr(regAddr(0, 6), 32'h01);
    check("irq_collide", 32'(irq), 32'(IRQ_EN));
    rd(regAddr(0, 6), IRQ_EN ? 32'h01 : 32'h0, "ifr0_collide");

    // Pins high through reset: priming suppresses spurious rises
    pin = 16'hFFFF;
    doReset();
    wr(regAddr(0, 4), 32'hFF);
    wr(regAddr(1, 4), 32'hFF);
    idle(4);
    rd(regAddr(0, 6), 32'h0, "prime_ifr0");
    rd(regAddr(1, 6), 32'h0, "prime_ifr1");
    check("prime_irq", 32'(irq), 32'h0);
    rd(regAddr(0, 4), IRQ_EN ? 32'hFF : 32'h0, "rise0_read");
    rd(regAddr(0, 2), 32'hFF, "pin0_high");
    wr(regAddr(0, 5), 32'hFF);
    wr(regAddr(1, 5), 32'hFF);
    pin = 16'h0000;
    idle(3);
    check("fall_irq", 32'(irq), 32'(IRQ_EN));
    rd(regAddr(0, 6), IRQ_EN ? 32'hFF : 32'h0, "fall_ifr0");
    rd(regAddr(1, 2), 32'h00, "pin1_low");

    // Random traffic, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      addr   = 11'(BASE - 4 + int'($urandom_range(0, 8 * NP + 7)));
      wrData = $urandom;
      wrEn   = 1'($urandom_range(0, 1));
      rdEn   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pin = 16'($urandom);
      tick();
      if (i == 200) doReset();
    end
    wrEn = 1'b0;
    rdEn = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised multi-port GPIO peripheral on the core data bus, successor to the single 8-bit DDR/PVL/PIN port. It provides `NUM_PORTS` ports of `PORT_SIZE` bits each. Each port has pin synchronisation, a write-1-to-toggle register, and per-bit rising/falling edge detection with sticky flags and a combined interrupt line. The top level wraps the `ddr`/`pvl`/`pin` vectors in per-bit IOBUFs.

## Interface
- `XLEN`, 32, data bus width.
- `ADDRW`, 11, bus address width (word-register index).
- `NUM_PORTS`, 2, number of ports (1..8).
- `PORT_SIZE`, 8, bits per port (1..`XLEN`).
- `BASE_ADDR`, 11'h408, address of port 0 DDR; must be a multiple of 8.
- `SYNC_STAGES`, 2, pin synchroniser depth (≥2).

Ports:
- `clk` in 1: single clock.
- `rstB` in 1: asynchronous, active-low reset.
- `addr` in `ADDRW`: register address.
- `wrData` in `XLEN`: write data; bits [`PORT_SIZE`-1:0] used.
- `wrEn` in 1: write strobe.
- `rdEn` in 1: read strobe.
- `dataOut` out `XLEN`: read data, zero-extended.
- `outEn` out 1: read data valid.
- `ddr` out `NUM_PORTS*PORT_SIZE`: direction; 1 = output. Port p occupies bits [p*`PORT_SIZE` +: `PORT_SIZE`].
- `pvl` out `NUM_PORTS*PORT_SIZE`: output value.
- `pin` in `NUM_PORTS*PORT_SIZE`: asynchronous pad input.
- `irq` out 1: OR of all unmasked flags.

## Operation
- Register address = `BASE_ADDR` + 8*p + offset. Addresses outside [`BASE_ADDR`, `BASE_ADDR`+8*`NUM_PORTS`) are ignored: no write, `outEn` stays 0.
- Offset 0, DDR (R/W).
- Offset 1, PVL (R/W).
- Offset 2, PIN (RO): synchronised pin value. Writes are ignored.
- Offset 3, TGL (WO): PVL ^= wrData. Reads return 0.
- Offset 4, RISE (R/W): rising-edge enable mask.
- Offset 5, FALL (R/W): falling-edge enable mask.
- Offset 6, IFR (R/W1C): sticky flags. Writing 1 clears a bit; writing 0 has no effect.
- Offset 7: reserved. Reads return 0; writes are ignored.
- Synchroniser: a `SYNC_STAGES` flop chain per bit, followed by one "previous" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
- Flag set: IFR[b] <= IFR[b] | (rise[b] & RISE[b]) | (fall[b] & FALL[b]), ANDed with clear-mask when IFR is written.
  - If a set and a W1C hit the same bit in the same cycle, set wins.
- Edge priming: after reset release, a counter masks edge detection for `SYNC_STAGES`+1 cycles. This keeps pins that are high at reset from flagging. The counter saturates, then detection is live.
- `irq` = |(all IFR bits), driven directly from the flag flops.
- Edges are detected regardless of DDR. An output-driven pin loops back through the pad.

## Timing
- Reset (async) values:
  - `ddr`, `pvl`, RISE, FALL, IFR, synchroniser and prev flops: 0.
  - `dataOut` = 0, `outEn` = 0, `irq` = 0.
  - Priming counter = 0.
- Writes take effect at the posedge sampling `wrEn`. `ddr`/`pvl` change at that edge.
- Reads: `dataOut`/`outEn` are registered, valid the cycle after `rdEn` for one cycle.
  - `dataOut` = 0 whenever `outEn` = 0.
  - A read with no `rdEn` keeps `outEn` low.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Pin change to PIN readable: `SYNC_STAGES` cycles.
- Pin change to IFR/`irq` high: `SYNC_STAGES`+1 cycles.
- W1C to `irq` low: next edge, provided no other flag remains set.
- Reset asserted mid-operation: all state clears immediately and pending flags are lost. Priming restarts on release.

## Configuration
- `GPIO_BANK_IRQ_EN` defined: RISE, FALL and IFR, edge detection, the priming counter and `irq` are implemented.
- Not defined:
  - Offsets 4–6 read 0 and ignore writes.
  - `irq` is tied 0.
  - The prev flop and the priming counter are removed.
  - DDR/PVL/PIN/TGL behaviour and read latency are unchanged.

## Test plan
- Reset then read all 8*`NUM_PORTS` offsets → every read returns 0 with `outEn` one cycle after `rdEn`. Out-of-range address 11'h400 → `outEn` never asserts.
- Write DDR1=8'hF0, PVL1=8'hA5, then TGL1=8'h0F → `ddr[15:8]`=F0, `pvl[15:8]`=AA. TGL read returns 0.
- Drive `pin[3]` 0→1 with RISE0=8'h08 → PIN0 reads 8'h08 after 2 cycles. IFR0=8'h08 and `irq`=1 after 3 cycles. Write IFR0=8'h08 → `irq`=0 next cycle.
- Hold `pin`=all-ones through reset with RISE=FF written immediately after release → IFR stays 0 (priming mask). A later 1→0 with FALL=FF sets IFR=FF.
- W1C of IFR bit 0 in the same cycle as a new rising edge on bit 0 → IFR bit 0 remains 1 and `irq` stays high.
- Build without `GPIO_BANK_IRQ_EN`: toggle pins with RISE written FF → `irq` stays 0, offset 4 reads 0, PIN still tracks pins.
